int_sequencer: RTL and testbench

//  Sequences interrupt entry and return around the priority interrupt unit. Consumes its

---
 rtl/int_sequencer.sv | 143 ++++++++++++++
 tb/tb_int_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sequencer.sv
// Interrupt entry/return sequencer between the priority interrupt unit and the PC/fetch stage.
// Drains the pipeline, stacks {PC, mask} per nesting level, vectors to the handler, and restores on ERET.
module int_sequencer #(
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] VEC_BASE   = 'h100,
  parameter logic [PC_W-1:0] VEC_STRIDE = 'h20,
  parameter int unsigned     DEPTH      = 3
) (
  input  logic            in_CLK,
  input  logic            in_RST,
  input  logic            in_break,
  input  logic [1:0]      in_code,
  input  logic [PC_W-1:0] in_PC,
  input  logic            in_busy,
  input  logic            in_ERET,
  input  logic [3:0]      in_INM_sw,
  output logic            out_IE,
  output logic [3:0]      out_INM,
  output logic [3:0]      out_IG,
  output logic            out_pc_ld,
  output logic [PC_W-1:0] out_pc,
  output logic            out_hold,
  output logic [1:0]      out_depth,
  output logic            out_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_SAVE,
    S_JUMP,
    S_RESTORE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_ie;
  logic [3:0]      r_lvl_mask;
  logic [1:0]      r_depth;
  logic [1:0]      r_k;
  logic [PC_W-1:0] r_stk_pc   [DEPTH];
  logic [3:0]      r_stk_mask [DEPTH];

  logic            w_ie;
  logic            w_take;
  logic [3:0]      w_kmask;
  logic [PC_W-1:0] w_vec;
  logic [1:0]      w_top;

  assign w_ie      = r_ie && (r_state == S_IDLE) && (32'(r_depth) < DEPTH);
  assign w_take    = !in_ERET && in_break && w_ie && (in_code != 2'b00);
  assign w_top     = r_depth - 2'd1;
  assign w_vec     = VEC_BASE + PC_W'(r_k - 2'd1) * VEC_STRIDE;

  assign out_IE    = w_ie;
  assign out_INM   = r_lvl_mask | in_INM_sw;
  assign out_depth = r_depth;

  // Mask covering levels 1..k; its top set bit doubles as the one-hot request clear.
  always_comb begin
    w_kmask = 4'b0000;
    case (r_k)
      2'd1:    w_kmask = 4'b0001;
      2'd2:    w_kmask = 4'b0011;
      2'd3:    w_kmask = 4'b0111;
      default: w_kmask = 4'b0000;
    endcase
  end

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      r_state    <= S_IDLE;
      r_ie       <= 1'b1;
      r_lvl_mask <= '0;
      r_depth    <= '0;
      r_k        <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_stk_pc[i]   <= '0;
        r_stk_mask[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_ie    <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_take) r_k <= in_code;
        end
        S_SAVE: begin
          r_stk_pc[r_depth]   <= in_PC;
          r_stk_mask[r_depth] <= r_lvl_mask;
          r_depth             <= r_depth + 2'd1;
          r_lvl_mask          <= r_lvl_mask | w_kmask;
        end
        S_RESTORE: begin
          r_depth    <= w_top;
          r_lvl_mask <= r_stk_mask[w_top];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    out_hold  = 1'b0;
    out_IG    = 4'b0000;
    out_pc_ld = 1'b0;
    out_pc    = '0;
    out_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // ERET has priority; a concurrent break is seen again once back in IDLE.
        if (in_ERET) begin
          if (r_depth != 2'd0) w_next  = S_RESTORE;
          else                 out_err = 1'b1;
        end else if (w_take) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_hold = 1'b1;
        if (!in_busy) w_next = S_SAVE;
      end
      S_SAVE: begin
        out_hold = 1'b1;
        out_IG   = {1'b0, w_kmask[2:0] ^ {1'b0, w_kmask[2:1]}};
        w_next   = S_JUMP;
      end
      S_JUMP: begin
        out_pc_ld = 1'b1;
        out_pc    = w_vec;
        w_next    = S_IDLE;
      end
      S_RESTORE: begin
        out_pc_ld = 1'b1;
        out_pc    = r_stk_pc[w_top];
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Scoreboard bench for int_sequencer: directed scenarios followed by random break/ERET traffic
// checked against a queue-based nesting model.
module tb_int_sequencer;

  localparam int unsigned PC_W = 32;
  localparam logic [31:0] VB   = 32'h100;
  localparam logic [31:0] VS   = 32'h20;

  logic        in_CLK, in_RST, in_break, in_busy, in_ERET;
  logic [1:0]  in_code;
  logic [31:0] in_PC;
  logic [3:0]  in_INM_sw;
  logic        out_IE, out_pc_ld, out_hold, out_err;
  logic [3:0]  out_INM, out_IG;
  logic [31:0] out_pc;
  logic [1:0]  out_depth;

  int_sequencer #(
    .PC_W(PC_W), .VEC_BASE(VB), .VEC_STRIDE(VS), .DEPTH(3)
  ) dut (
    .in_CLK(in_CLK), .in_RST(in_RST), .in_break(in_break), .in_code(in_code),
    .in_PC(in_PC), .in_busy(in_busy), .in_ERET(in_ERET), .in_INM_sw(in_INM_sw),
    .out_IE(out_IE), .out_INM(out_INM), .out_IG(out_IG), .out_pc_ld(out_pc_ld),
    .out_pc(out_pc), .out_hold(out_hold), .out_depth(out_depth), .out_err(out_err)
  );

  initial in_CLK = 1'b0;
  always #5 in_CLK = ~in_CLK;

  int cyc = 0;
  always @(posedge in_CLK) cyc <= cyc + 1;

  typedef enum int {EV_IG = 0, EV_PC = 1, EV_ERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          cyc;
    logic [31:0] val;
  } ev_t;

  ev_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Reference nesting model
  logic [31:0] m_pc[$];
  logic [3:0]  m_mask_stk[$];
  logic [3:0]  m_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  ev_t         mon_e;
  int          mon_kind;
  logic [31:0] mon_val;
  always @(negedge in_CLK) begin
    if (!in_RST) begin
      if (!out_pc_ld) chk("pc_zero_without_ld", out_pc, 32'h0);
      if (out_IG != 4'b0 || out_pc_ld || out_err) begin
        mon_kind = (out_IG != 4'b0) ? EV_IG : (out_pc_ld ? EV_PC : EV_ERR);
        mon_val  = (mon_kind == EV_IG) ? {28'h0, out_IG} :
                   (mon_kind == EV_PC) ? out_pc : {31'h0, out_err};
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d val %0h expected none (cycle %0d)",
                   mon_kind, mon_val, cyc);
        end else begin
          mon_e = q.pop_front();
          chk("event_kind", mon_kind, mon_e.kind);
          chk("event_cycle", cyc, mon_e.cyc);
          chk("event_value", mon_val, mon_e.val);
        end
      end
    end
  end

  function automatic int hi_level(input logic [3:0] m);
    if (m[2]) return 3;
    if (m[1]) return 2;
    if (m[0]) return 1;
    return 0;
  endfunction

  task automatic step();
    @(posedge in_CLK);
    #1;
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, "_depth"}, out_depth, m_pc.size());
    chk({tag, "_inm"}, out_INM, m_mask | in_INM_sw);
    chk({tag, "_hold"}, out_hold, 1'b0);
  endtask

  task automatic do_reset();
    in_RST = 1'b1; in_break = 0; in_busy = 0; in_ERET = 0; in_code = 0; in_PC = 0;
    step();
    step();
    q.delete();
    m_pc.delete();
    m_mask_stk.delete();
    m_mask = 4'b0;
    chk("rst_ie", out_IE, 1'b1);
    chk("rst_inm", out_INM, in_INM_sw);
    chk("rst_depth", out_depth, 2'd0);
    chk("rst_ig", out_IG, 4'b0);
    chk("rst_pcld", out_pc_ld, 1'b0);
    in_RST = 1'b0;
    step();
  endtask

  // Break sampled at the next edge; busy held for b DRAIN cycles.
  task automatic do_break(input logic [1:0] code, input int b, input logic [31:0] pc);
    int  n;
    ev_t e;
    n = cyc;
    chk("ie_before_break", out_IE, 1'b1);
    in_break = 1'b1; in_code = code; in_PC = pc; in_busy = 1'b0;
    e.kind = EV_IG; e.cyc = n + 2 + b; e.val = 32'(1) << (code - 1);
    q.push_back(e);
    e.kind = EV_PC; e.cyc = n + 3 + b; e.val = VB + 32'(code - 1) * VS;
    q.push_back(e);
    m_pc.push_back(pc);
    m_mask_stk.push_back(m_mask);
    m_mask = m_mask | 4'((1 << code) - 1);
    step();
    in_break = 1'b0;
    in_code  = 2'($urandom);
    for (int i = 0; i < b; i++) begin
      in_busy = 1'b1;
      chk("hold_drain", out_hold, 1'b1);
      step();
    end
    in_busy = 1'b0;
    chk("hold_drain_end", out_hold, 1'b1);
    step();
    chk("hold_save", out_hold, 1'b1);
    step();
    in_PC = $urandom;
    step();
    chk_idle_state("after_entry");
  endtask

  task automatic do_eret(input bit with_break);
    int  n;
    int  hi;
    ev_t e;
    n = cyc;
    if (m_pc.size() == 0) begin
      e.kind = EV_ERR; e.cyc = n; e.val = 32'h1;
      q.push_back(e);
      in_ERET = 1'b1;
      step();
      in_ERET = 1'b0;
      chk("err_stays_idle", out_IE, 1'b1);
      chk_idle_state("after_err");
    end else begin
      e.kind = EV_PC; e.cyc = n + 1; e.val = m_pc.pop_back();
      q.push_back(e);
      m_mask = m_mask_stk.pop_back();
      hi = hi_level(m_mask);
      in_ERET  = 1'b1;
      in_break = with_break && (hi < 3);
      in_code  = 2'(hi + 1);
      step();
      in_ERET = 1'b0;
      chk("ie_low_in_restore", out_IE, 1'b0);
      step();
      chk_idle_state("after_restore");
      if (in_break) do_break(2'(hi + 1), $urandom_range(0, 3), $urandom);
    end
  endtask

  task automatic ignored_break();
    chk("ie_low_at_full", out_IE, 1'b0);
    in_break = 1'b1; in_code = 2'd3;
    step();
    in_break = 1'b0;
    step();
    step();
    chk_idle_state("full_ignore");
  endtask

  initial begin
    in_RST = 1'b1; in_break = 0; in_busy = 0; in_ERET = 0; in_code = 0; in_PC = 0;
    in_INM_sw = 4'b0;
    m_mask = 4'b0;

    // 1, 2: simple entry then nested entry behind a busy pipeline
    do_reset();
    do_break(2'b01, 0, 32'h1000);
    chk("t1_inm", out_INM, 4'b0001);
    do_break(2'b10, 4, 32'h2000);
    chk("t2_depth", out_depth, 2'd2);

    // 3: nest 01 then 11, return restores mask 0001
    do_reset();
    do_break(2'b01, 1, 32'h3000);
    do_break(2'b11, 0, 32'h3100);
    chk("t3_depth", out_depth, 2'd2);
    do_eret(1'b0);
    chk("t3_inm", out_INM, 4'b0001);

    // 4: ERET with nothing stacked
    do_reset();
    do_eret(1'b0);

    // 5: ERET and break together at depth 1
    do_reset();
    do_break(2'b01, 0, 32'h5000);
    do_eret(1'b1);
    chk("t5_depth", out_depth, 2'd1);

    // Full stack ignores breaks
    do_break(2'b10, 2, 32'h5100);
    do_break(2'b11, 0, 32'h5200);
    ignored_break();

    // 6: reset asserted during SAVE
    in_INM_sw = 4'b1010;
    do_reset();
    in_break = 1'b1; in_code = 2'b10; in_PC = 32'h6000;
    step();
    in_break = 1'b0;
    step();
    chk("t6_in_save", out_IG, 4'b0010);
    in_RST = 1'b1;
    #1;
    chk("t6_ig", out_IG, 4'b0);
    chk("t6_hold", out_hold, 1'b0);
    chk("t6_pcld", out_pc_ld, 1'b0);
    chk("t6_depth", out_depth, 2'd0);
    chk("t6_inm", out_INM, 4'b1010);
    chk("t6_ie", out_IE, 1'b1);
    q.delete();
    m_pc.delete();
    m_mask_stk.delete();
    m_mask = 4'b0;
    step();
    in_RST = 1'b0;
    step();
    chk_idle_state("t6_after");

    // Random traffic
    for (int it = 0; it < 150; it++) begin
      int op;
      int hi;
      op = $urandom_range(0, 9);
      hi = hi_level(m_mask);
      if ($urandom_range(0, 7) == 0) in_INM_sw = 4'($urandom);
      if (op < 5) begin
        if (m_pc.size() < 3 && hi < 3)
          do_break(2'($urandom_range(hi + 1, 3)), $urandom_range(0, 5), $urandom);
        else
          do_eret(1'b0);
      end else if (op < 8) begin
        do_eret(1'($urandom_range(0, 1)));
      end else if (op == 9 && m_pc.size() == 3) begin
        ignored_break();
      end else begin
        in_busy = 1'($urandom);
        step();
        in_busy = 1'b0;
        chk_idle_state("idle_noise");
      end
    end

    step();
    step();
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
